// File: rtl/seq_mul_div.sv
// Sequential 8x8 unsigned multiply and 8/8 unsigned divide driven through the shared 8-bit ALU.
// Each operation takes 8 two-cycle iterations; the done pulse follows in cycle 17.
module seq_mul_div (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       op,
   input  logic [7:0] operando_a,
   input  logic [7:0] operando_b,
   output logic       busy,
   output logic       done,
   output logic [7:0] resultado_hi,
   output logic [7:0] resultado_lo,
   output logic       div_zero,
   output logic       alu_sel,
   output logic [7:0] alu_entrada1,
   output logic [7:0] alu_entrada2,
   output logic [2:0] alu_sinal,
   input  logic [7:0] alu_saida
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC_A,
      S_CALC_B,
      S_DONE
   } state_t;

   localparam logic       OP_MUL  = 1'b0;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   state_t     r_state;
   logic [2:0] r_iter;
   logic       r_op;
   logic [7:0] r_m;      // MUL: multiplicand M, DIV: divisor D
   logic [7:0] r_hi;     // MUL: P_hi,           DIV: remainder R
   logic [7:0] r_lo;     // MUL: P_lo,           DIV: quotient Q
   logic [7:0] r_s;      // MUL: partial sum S,  DIV: trial value T
   logic       r_lt;
   logic       r_ovf;
   logic       r_busy;
   logic       r_done;
   logic [7:0] r_res_hi;
   logic [7:0] r_res_lo;
   logic       r_div_zero;

   logic [7:0] w_addend;
   logic [7:0] w_div_t;
   logic       w_div_take;
   logic [7:0] w_hi_nxt;
   logic [7:0] w_lo_nxt;

   assign w_addend   = r_lo[0] ? r_m : 8'h00;
   assign w_div_t    = {r_hi[6:0], r_lo[7]};
   assign w_div_take = r_ovf | ~r_lt;

   // End-of-iteration values; in CALC_B alu_saida is the SLT carry (MUL) or T-D (DIV).
   assign w_hi_nxt = (r_op == OP_MUL) ? {alu_saida[0], r_s[7:1]}
                                      : (w_div_take ? alu_saida : r_s);
   assign w_lo_nxt = (r_op == OP_MUL) ? {r_s[0], r_lo[7:1]}
                                      : {r_lo[7:1], w_div_take};

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      alu_entrada1 = 8'h00;
      alu_entrada2 = 8'h00;
      alu_sinal    = ALU_AND;
      case (r_state)
         S_CALC_A: begin
            if (r_op == OP_MUL) begin
               alu_entrada1 = r_hi;
               alu_entrada2 = w_addend;
               alu_sinal    = ALU_ADD;
            end else begin
               alu_entrada1 = w_div_t;
               alu_entrada2 = r_m;
               alu_sinal    = ALU_SLT;
            end
         end
         S_CALC_B: begin
            alu_entrada1 = r_s;
            alu_entrada2 = (r_op == OP_MUL) ? w_addend : r_m;
            alu_sinal    = (r_op == OP_MUL) ? ALU_SLT : ALU_SUB;
         end
         default: ;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments only, so every register
   // sees the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_iter     <= 3'd0;
         r_op       <= OP_MUL;
         r_m        <= 8'h00;
         r_hi       <= 8'h00;
         r_lo       <= 8'h00;
         r_s        <= 8'h00;
         r_lt       <= 1'b0;
         r_ovf      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_res_hi   <= 8'h00;
         r_res_lo   <= 8'h00;
         r_div_zero <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op       <= op;
                  r_div_zero <= 1'b0;
                  if (op != OP_MUL && operando_b == 8'h00) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_res_hi   <= operando_a;
                     r_res_lo   <= 8'hFF;
                     r_div_zero <= 1'b1;
                  end else begin
                     r_state <= S_CALC_A;
                     r_busy  <= 1'b1;
                     r_iter  <= 3'd0;
                     r_m     <= (op == OP_MUL) ? operando_a : operando_b;
                     r_lo    <= (op == OP_MUL) ? operando_b : operando_a;
                     r_hi    <= 8'h00;
                  end
               end
            end
            S_CALC_A: begin
               r_state <= S_CALC_B;
               if (r_op == OP_MUL) begin
                  r_s <= alu_saida;
               end else begin
                  r_s   <= w_div_t;
                  r_lt  <= alu_saida[0];
                  r_ovf <= r_hi[7];
                  r_lo  <= {r_lo[6:0], 1'b0};
               end
            end
            S_CALC_B: begin
               r_hi <= w_hi_nxt;
               r_lo <= w_lo_nxt;
               if (r_iter == 3'd7) begin
                  // The done cycle is spent in IDLE so a start there is taken at edge 17.
                  r_state  <= S_IDLE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_res_hi <= w_hi_nxt;
                  r_res_lo <= w_lo_nxt;
                  r_iter   <= 3'd0;
               end else begin
                  r_state <= S_CALC_A;
                  r_iter  <= r_iter + 3'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy         = r_busy;
   assign alu_sel      = r_busy;
   assign done         = r_done;
   assign resultado_hi = r_res_hi;
   assign resultado_lo = r_res_lo;
   assign div_zero     = r_div_zero;

endmodule

// File: tb/tb_seq_mul_div.sv
// Randomized and directed bench for seq_mul_div with a behavioural ALU and an arithmetic
// reference model for product, quotient and remainder.
module tb_seq_mul_div;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       op;
   logic [7:0] operando_a;
   logic [7:0] operando_b;
   logic       busy;
   logic       done;
   logic [7:0] resultado_hi;
   logic [7:0] resultado_lo;
   logic       div_zero;
   logic       alu_sel;
   logic [7:0] alu_entrada1;
   logic [7:0] alu_entrada2;
   logic [2:0] alu_sinal;
   logic [7:0] alu_saida;

   int total = 0;
   int bad   = 0;

   seq_mul_div dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .op           (op),
      .operando_a   (operando_a),
      .operando_b   (operando_b),
      .busy         (busy),
      .done         (done),
      .resultado_hi (resultado_hi),
      .resultado_lo (resultado_lo),
      .div_zero     (div_zero),
      .alu_sel      (alu_sel),
      .alu_entrada1 (alu_entrada1),
      .alu_entrada2 (alu_entrada2),
      .alu_sinal    (alu_sinal),
      .alu_saida    (alu_saida)
   );

   always #5 clock = ~clock;

   // Shared processor ALU
   always_comb begin
      case (alu_sinal)
         3'b000:  alu_saida = alu_entrada1 & alu_entrada2;
         3'b001:  alu_saida = alu_entrada1 | alu_entrada2;
         3'b010:  alu_saida = alu_entrada1 + alu_entrada2;
         3'b011:  alu_saida = alu_entrada1 - alu_entrada2;
         3'b100:  alu_saida = {7'd0, alu_entrada1 < alu_entrada2};
         default: alu_saida = 8'h00;
      endcase
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic model(input logic o, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] hi, output logic [7:0] lo, output logic dz);
      logic [15:0] p;
      p  = 16'(a) * 16'(b);
      dz = 1'b0;
      if (!o) begin
         hi = p[15:8];
         lo = p[7:0];
      end else if (b == 8'h00) begin
         hi = a;
         lo = 8'hFF;
         dz = 1'b1;
      end else begin
         hi = a % b;
         lo = a / b;
      end
   endtask

   // Checks cycles 1..16 of an accepted operation; on return the bench sits in cycle 17.
   task automatic check_busy_phase(input string name, input logic o, input logic [7:0] a,
                                   input logic [7:0] b, input int first_cycle);
      logic [2:0] exp_sinal;
      for (int c = 1; c <= 16; c++) begin
         total++;
         if (busy !== 1'b1 || alu_sel !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s busy cycle %0d: busy=%b alu_sel=%b done=%b want 1/1/0",
                     name, first_cycle + c - 1, busy, alu_sel, done);
         end
         if (!o) exp_sinal = (c % 2 == 1) ? 3'b010 : 3'b100;
         else    exp_sinal = (c % 2 == 1) ? 3'b100 : 3'b011;
         total++;
         if (alu_sinal !== exp_sinal) begin
            bad++;
            $display("FAIL %s sinal cycle %0d: got %b want %b", name, first_cycle + c - 1,
                     alu_sinal, exp_sinal);
         end
         if (c == 1) begin
            total++;
            if (!o && (alu_entrada1 !== 8'h00 || alu_entrada2 !== (b[0] ? a : 8'h00))) begin
               bad++;
               $display("FAIL %s first mul drive: got %h/%h", name, alu_entrada1, alu_entrada2);
            end else if (o && (alu_entrada1 !== {7'd0, a[7]} || alu_entrada2 !== b)) begin
               bad++;
               $display("FAIL %s first div drive: got %h/%h", name, alu_entrada1, alu_entrada2);
            end
         end
         step();
      end
   endtask

   task automatic check_done_cycle(input string name, input logic o, input logic [7:0] a,
                                   input logic [7:0] b);
      logic [7:0] ehi, elo;
      logic       edz;
      model(o, a, b, ehi, elo, edz);
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || alu_sel !== 1'b0) begin
         bad++;
         $display("FAIL %s done cycle: done=%b busy=%b alu_sel=%b want 1/0/0",
                  name, done, busy, alu_sel);
      end
      total++;
      if (resultado_hi !== ehi || resultado_lo !== elo || div_zero !== edz) begin
         bad++;
         $display("FAIL %s result: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                  name, resultado_hi, resultado_lo, div_zero, ehi, elo, edz);
      end
      total++;
      if (alu_entrada1 !== 8'h00 || alu_entrada2 !== 8'h00 || alu_sinal !== 3'b000) begin
         bad++;
         $display("FAIL %s idle drive: got %h/%h/%b want 00/00/000",
                  name, alu_entrada1, alu_entrada2, alu_sinal);
      end
   endtask

   // Full operation from IDLE with start pulsed for one cycle; ends one cycle after done.
   task automatic run_op(input string name, input logic o, input logic [7:0] a,
                         input logic [7:0] b);
      start      = 1'b1;
      op         = o;
      operando_a = a;
      operando_b = b;
      step();
      start      = 1'b0;
      op         = 1'($urandom);
      operando_a = 8'($urandom);
      operando_b = 8'($urandom);
      if (!(o && b == 8'h00)) check_busy_phase(name, o, a, b, 1);
      check_done_cycle(name, o, a, b);
      step();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s after done: done=%b busy=%b want 0/0", name, done, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      op = 1'b0;
      operando_a = 8'h00;
      operando_b = 8'h00;
      step();
      step();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || alu_sel !== 1'b0 || div_zero !== 1'b0 ||
          resultado_hi !== 8'h00 || resultado_lo !== 8'h00 || alu_entrada1 !== 8'h00 ||
          alu_entrada2 !== 8'h00 || alu_sinal !== 3'b000) begin
         bad++;
         $display("FAIL reset state: busy=%b done=%b sel=%b dz=%b hi=%h lo=%h drive=%h/%h/%b",
                  busy, done, alu_sel, div_zero, resultado_hi, resultado_lo,
                  alu_entrada1, alu_entrada2, alu_sinal);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_directed();
      run_op("mul_ff_ff", 1'b0, 8'hFF, 8'hFF);
      run_op("mul_13_11", 1'b0, 8'd13, 8'd11);
      run_op("mul_0_a5",  1'b0, 8'h00, 8'hA5);
      run_op("mul_80_02", 1'b0, 8'h80, 8'h02);
      run_op("div_200_7", 1'b1, 8'd200, 8'd7);
      run_op("div_ff_80", 1'b1, 8'hFF, 8'h80);
      run_op("div_5_9",   1'b1, 8'd5, 8'd9);
   endtask

   task automatic test_div_zero();
      start      = 1'b1;
      op         = 1'b1;
      operando_a = 8'h37;
      operando_b = 8'h00;
      step();
      check_done_cycle("div_zero", 1'b1, 8'h37, 8'h00);
      // start stays high with a MUL during the DONE cycle; it must be ignored
      op         = 1'b0;
      operando_a = 8'd2;
      operando_b = 8'd3;
      step();
      total++;
      if (busy !== 1'b0 || alu_sel !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL div_zero start in done: busy=%b sel=%b done=%b want 0/0/0",
                  busy, alu_sel, done);
      end
      total++;
      if (div_zero !== 1'b1) begin
         bad++;
         $display("FAIL div_zero hold: got %b want 1", div_zero);
      end
      step();
      start      = 1'b0;
      operando_a = 8'($urandom);
      operando_b = 8'($urandom);
      total++;
      if (div_zero !== 1'b0) begin
         bad++;
         $display("FAIL div_zero clear on start: got %b want 0", div_zero);
      end
      check_busy_phase("mul_2_3", 1'b0, 8'd2, 8'd3, 3);
      check_done_cycle("mul_2_3", 1'b0, 8'd2, 8'd3);
      step();
   endtask

   task automatic test_back_to_back();
      logic       o1, o2;
      logic [7:0] a1, b1, a2, b2;
      o1 = 1'b0;   a1 = 8'($urandom); b1 = 8'($urandom);
      o2 = 1'b1;   a2 = 8'($urandom); b2 = 8'($urandom_range(255, 1));
      start      = 1'b1;
      op         = o1;
      operando_a = a1;
      operando_b = b1;
      step();
      op         = o2;
      operando_a = a2;
      operando_b = b2;
      check_busy_phase("b2b_first", o1, a1, b1, 1);
      check_done_cycle("b2b_first", o1, a1, b1);
      step();
      start      = 1'b0;
      op         = 1'b0;
      operando_a = 8'($urandom);
      operando_b = 8'($urandom);
      check_busy_phase("b2b_second", o2, a2, b2, 18);
      check_done_cycle("b2b_second", o2, a2, b2);
      step();
   endtask

   task automatic test_reset_mid();
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      start      = 1'b1;
      op         = 1'b0;
      operando_a = a;
      operando_b = b;
      step();
      start = 1'b0;
      for (int c = 1; c < 8; c++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || alu_sel !== 1'b0 || div_zero !== 1'b0 ||
          resultado_hi !== 8'h00 || resultado_lo !== 8'h00 || alu_entrada1 !== 8'h00 ||
          alu_entrada2 !== 8'h00 || alu_sinal !== 3'b000) begin
         bad++;
         $display("FAIL reset_mid state: busy=%b done=%b sel=%b hi=%h lo=%h sinal=%b",
                  busy, done, alu_sel, resultado_hi, resultado_lo, alu_sinal);
      end
      for (int c = 0; c < 12; c++) begin
         total++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid aborted op: done=%b busy=%b want 0/0", done, busy);
         end
         step();
      end
      run_op("after_reset", 1'b0, a, b);
   endtask

   task automatic test_random();
      logic       o;
      logic [7:0] a, b;
      for (int n = 0; n < 24; n++) begin
         o = 1'($urandom);
         a = 8'($urandom);
         b = ($urandom_range(5, 0) == 0) ? 8'h00 : 8'($urandom);
         run_op("random", o, a, b);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
